// File: rtl/if_fetcher_pkg.sv
// rtl/if_fetcher_pkg.sv - shared types, constants and state encoding for the IF fetcher
package if_fetcher_pkg;

  typedef logic [31:0] addr_type_t;
  typedef logic [31:0] ins_type_t;

  localparam logic       TRUE      = 1'b1;
  localparam logic       FALSE     = 1'b0;
  localparam addr_type_t ZERO_WORD = 32'h0000_0000;
  localparam addr_type_t PC_STEP   = 32'd4;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_fetcher.sv
// rtl/if_fetcher.sv - instruction fetch FSM: ICache lookup, miss refill via memctrl, ROB redirect
module if_fetcher
  import if_fetcher_pkg::*;
#(
  parameter addr_type_t RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic [31:0] query_pc,
  input  logic        hit_from_icache,
  input  logic [31:0] inst_from_icache,
  output logic        ena_to_icache,
  output logic [31:0] addr_to_icache,
  output logic [31:0] inst_to_icache,
  output logic        ena_to_memctrl,
  output logic [31:0] addr_to_memctrl,
  input  logic        ok_flag_from_memctrl,
  input  logic [31:0] inst_from_memctrl,
  output logic        ok_flag_to_dsp,
  output logic [31:0] inst_to_dsp,
  output logic [31:0] pc_to_dsp,
  input  logic        global_full,
  input  logic        rollback_flag,
  input  logic [31:0] target_pc_from_rob
);

  if_state_e  state_q;
  addr_type_t pc_q;
  logic       ok_dsp_q;
  ins_type_t  inst_dsp_q;
  addr_type_t pc_dsp_q;
  logic       ena_ic_q;
  addr_type_t addr_ic_q;
  ins_type_t  inst_ic_q;
  logic       ena_mem_q;
  addr_type_t addr_mem_q;

  assign query_pc        = pc_q;
  assign ok_flag_to_dsp  = ok_dsp_q;
  assign inst_to_dsp     = inst_dsp_q;
  assign pc_to_dsp       = pc_dsp_q;
  assign ena_to_icache   = ena_ic_q;
  assign addr_to_icache  = addr_ic_q;
  assign inst_to_icache  = inst_ic_q;
  assign ena_to_memctrl  = ena_mem_q;
  assign addr_to_memctrl = addr_mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ok_dsp_q   <= FALSE;
      inst_dsp_q <= ZERO_WORD;
      pc_dsp_q   <= ZERO_WORD;
      ena_ic_q   <= FALSE;
      addr_ic_q  <= ZERO_WORD;
      inst_ic_q  <= ZERO_WORD;
      ena_mem_q  <= FALSE;
      addr_mem_q <= ZERO_WORD;
    end else if (rdy) begin
      ok_dsp_q <= FALSE;
      ena_ic_q <= FALSE;
      // The fill is independent of rollback so a line already fetched is never wasted.
      if (state_q == WAIT_MEM && ok_flag_from_memctrl) begin
        ena_ic_q  <= TRUE;
        addr_ic_q <= addr_mem_q;
        inst_ic_q <= inst_from_memctrl;
        ena_mem_q <= FALSE;
        state_q   <= IDLE;
      end
      if (rollback_flag) begin
        pc_q      <= target_pc_from_rob;
        ena_mem_q <= FALSE;
        state_q   <= IDLE;
      end else if (state_q == IDLE && !global_full) begin
        if (hit_from_icache) begin
          ok_dsp_q   <= TRUE;
          inst_dsp_q <= inst_from_icache;
          pc_dsp_q   <= pc_q;
          pc_q       <= pc_q + PC_STEP;
        end else begin
          ena_mem_q  <= TRUE;
          addr_mem_q <= pc_q;
          state_q    <= WAIT_MEM;
        end
      end
    end
  end

endmodule
